// File: rtl/controlador_barrido_bcd_pkg.sv
// controlador_barrido_bcd_pkg: shared FSM states, display constants and anode patterns
// Contents: estado_t (REPOSO/CONVERTIR/ACTUALIZAR), DIGITO_BLANCO, MAX_BCD, ANODO_0..3, anodo_de()
package controlador_barrido_bcd_pkg;
    typedef enum logic [1:0] {REPOSO, CONVERTIR, ACTUALIZAR} estado_t;
    localparam logic [3:0] DIGITO_BLANCO = 4'hF;
    localparam int MAX_BCD = 9999;
    localparam logic [3:0] ANODO_0 = 4'b1110;
    localparam logic [3:0] ANODO_1 = 4'b1101;
    localparam logic [3:0] ANODO_2 = 4'b1011;
    localparam logic [3:0] ANODO_3 = 4'b0111;
    function automatic logic [3:0] anodo_de(input logic [1:0] s);
        return s == 2'd0 ? ANODO_0 : s == 2'd1 ? ANODO_1 : s == 2'd2 ? ANODO_2 : ANODO_3;
    endfunction
endpackage

// File: rtl/controlador_barrido_bcd_conversor.sv
// conversor_binario_bcd: sequential double-dabble binary to 4-digit BCD converter
// Ports: clk, reset (async, active-high), inicio (start, honoured only when idle), dato (binary in),
//        ocupado (registered busy), actualizar (high during the result cycle), bcd (16-bit result)
module conversor_binario_bcd
    import controlador_barrido_bcd_pkg::*;
#(
    parameter int ANCHO_BIN = 14
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inicio,
    input  logic [ANCHO_BIN-1:0] dato,
    output logic                 ocupado,
    output logic                 actualizar,
    output logic [15:0]          bcd
);
    estado_t               estado;
    logic [ANCHO_BIN-1:0]  bin;
    logic [3:0]            iter;
    logic [15:0]           bcd_aj;
    for (genvar i = 0; i < 4; i++) begin : g_aj
        assign bcd_aj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end
    assign actualizar = estado == ACTUALIZAR;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado  <= REPOSO;
            bin     <= '0;
            bcd     <= '0;
            iter    <= '0;
            ocupado <= 1'b0;
        end else begin
            case (estado)
                REPOSO: if (inicio) begin
                    bin     <= dato;
                    bcd     <= '0;
                    iter    <= '0;
                    ocupado <= 1'b1;
                    estado  <= CONVERTIR;
                end
                CONVERTIR: begin
                    // Digits beyond 9999 fall off the top; the top level blanks them via overflow
                    {bcd, bin} <= {bcd_aj[14:0], bin, 1'b0};
                    iter       <= iter + 4'd1;
                    if (iter == 4'(ANCHO_BIN - 1)) estado <= ACTUALIZAR;
                end
                ACTUALIZAR: begin
                    ocupado <= 1'b0;
                    estado  <= REPOSO;
                end
                default: estado <= REPOSO;
            endcase
        end
    end
endmodule

// File: rtl/controlador_barrido_bcd.sv
// controlador_barrido_bcd: binary to BCD conversion with blanking and 4-digit multiplexed display scan
// Ports: clk, reset (async, active-high), dato_bin, cargar -> ocupado, listo, desbordado,
//        unidades/decenas/centenas/millares (BCD, 4'hF = blank), seleccion, anodos (active-low)
module controlador_barrido_bcd
    import controlador_barrido_bcd_pkg::*;
#(
    parameter int ANCHO_BIN    = 14,
    parameter int DIV_REFRESCO = 50000,
    parameter int BLANK_CEROS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ANCHO_BIN-1:0] dato_bin,
    input  logic                 cargar,
    output logic                 ocupado,
    output logic                 listo,
    output logic                 desbordado,
    output logic [3:0]           unidades,
    output logic [3:0]           decenas,
    output logic [3:0]           centenas,
    output logic [3:0]           millares,
    output logic [1:0]           seleccion,
    output logic [3:0]           anodos
);
    localparam int ANCHO_REF = DIV_REFRESCO > 2 ? $clog2(DIV_REFRESCO) : 1;
    localparam logic [3:0] DIGITO_INI = BLANK_CEROS != 0 ? DIGITO_BLANCO : 4'h0;
    logic                 actualizar, ovf, b_m, b_c, b_d;
    logic [15:0]          bcd;
    logic [ANCHO_REF-1:0] cnt_ref;
    conversor_binario_bcd #(.ANCHO_BIN(ANCHO_BIN)) u_conv (
        .clk        (clk),
        .reset      (reset),
        .inicio     (cargar),
        .dato       (dato_bin),
        .ocupado    (ocupado),
        .actualizar (actualizar),
        .bcd        (bcd)
    );
    // Leading-zero blanking cascades from millares down; unidades always shows
    assign b_m = BLANK_CEROS != 0 && bcd[15:12] == 4'd0;
    assign b_c = b_m && bcd[11:8] == 4'd0;
    assign b_d = b_c && bcd[7:4] == 4'd0;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf        <= 1'b0;
            listo      <= 1'b0;
            desbordado <= 1'b0;
            unidades   <= 4'h0;
            decenas    <= DIGITO_INI;
            centenas   <= DIGITO_INI;
            millares   <= DIGITO_INI;
        end else begin
            listo <= actualizar;
            if (cargar && !ocupado) ovf <= 32'(dato_bin) > MAX_BCD;
            if (actualizar) begin
                desbordado <= ovf;
                millares   <= ovf || b_m ? DIGITO_BLANCO : bcd[15:12];
                centenas   <= ovf || b_c ? DIGITO_BLANCO : bcd[11:8];
                decenas    <= ovf || b_d ? DIGITO_BLANCO : bcd[7:4];
                unidades   <= ovf ? DIGITO_BLANCO : bcd[3:0];
            end
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_ref   <= '0;
            seleccion <= 2'd0;
            anodos    <= ANODO_0;
        end else if (cnt_ref == ANCHO_REF'(DIV_REFRESCO - 1)) begin
            cnt_ref   <= '0;
            seleccion <= seleccion + 2'd1;
            anodos    <= anodo_de(seleccion + 2'd1);
        end else begin
            cnt_ref <= cnt_ref + 1'b1;
        end
    end
endmodule

// File: tb/tb_controlador_barrido_bcd.sv
// tb_controlador_barrido_bcd: directed self-checking bench for controlador_barrido_bcd
module tb_controlador_barrido_bcd;
    logic        clk = 0, reset = 0, cargar = 0;
    logic [13:0] dato_bin = '0;
    logic        ocupado, listo, desbordado, ocupado_nb, listo_nb, desbordado_nb;
    logic [3:0]  unidades, decenas, centenas, millares, anodos;
    logic [3:0]  unidades_nb, decenas_nb, centenas_nb, millares_nb, anodos_nb;
    logic [1:0]  seleccion, seleccion_nb;
    logic [15:0] dig, dig_nb;
    int errors = 0, checks = 0;
    assign dig    = {millares, centenas, decenas, unidades};
    assign dig_nb = {millares_nb, centenas_nb, decenas_nb, unidades_nb};
    always #5 clk = ~clk;
    controlador_barrido_bcd #(.ANCHO_BIN(14), .DIV_REFRESCO(4), .BLANK_CEROS(1)) dut (
        .clk(clk), .reset(reset), .dato_bin(dato_bin), .cargar(cargar),
        .ocupado(ocupado), .listo(listo), .desbordado(desbordado),
        .unidades(unidades), .decenas(decenas), .centenas(centenas), .millares(millares),
        .seleccion(seleccion), .anodos(anodos)
    );
    controlador_barrido_bcd #(.ANCHO_BIN(14), .DIV_REFRESCO(4), .BLANK_CEROS(0)) dut_nb (
        .clk(clk), .reset(reset), .dato_bin(dato_bin), .cargar(cargar),
        .ocupado(ocupado_nb), .listo(listo_nb), .desbordado(desbordado_nb),
        .unidades(unidades_nb), .decenas(decenas_nb), .centenas(centenas_nb), .millares(millares_nb),
        .seleccion(seleccion_nb), .anodos(anodos_nb)
    );
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset;
        cargar = 0;
        reset  = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0;
    endtask
    // Pulses cargar for one edge (E0) and waits for listo; lat = edges after E0, n_oc = busy samples
    task automatic convertir(input logic [13:0] v, output int lat, output int n_oc);
        dato_bin = v;
        cargar   = 1;
        tick();
        cargar = 0;
        lat    = 0;
        n_oc   = 0;
        while (!listo && lat < 40) begin
            if (ocupado) n_oc++;
            tick();
            lat++;
        end
    endtask
    task automatic test_reset;
        do_reset();
        checks++; if (dig !== 16'hFFF0) begin errors++; $display("FAIL reset_dig got=%h exp=fff0", dig); end
        checks++; if (dig_nb !== 16'h0000) begin errors++; $display("FAIL reset_dig_nb got=%h exp=0000", dig_nb); end
        checks++; if (seleccion !== 2'd0) begin errors++; $display("FAIL reset_sel got=%0d exp=0", seleccion); end
        checks++; if (anodos !== 4'b1110) begin errors++; $display("FAIL reset_anodos got=%b exp=1110", anodos); end
        checks++; if ({ocupado, listo, desbordado} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {ocupado, listo, desbordado}); end
    endtask
    task automatic test_conversion;
        int lat, n_oc;
        convertir(14'd1234, lat, n_oc);
        checks++; if (lat !== 15) begin errors++; $display("FAIL conv_latency got=%0d exp=15", lat); end
        checks++; if (n_oc !== 15) begin errors++; $display("FAIL conv_ocupado_cycles got=%0d exp=15", n_oc); end
        checks++; if (dig !== 16'h1234) begin errors++; $display("FAIL conv_dig got=%h exp=1234", dig); end
        checks++; if (desbordado !== 1'b0) begin errors++; $display("FAIL conv_ovf got=%b exp=0", desbordado); end
        checks++; if (ocupado !== 1'b0) begin errors++; $display("FAIL conv_busy_end got=%b exp=0", ocupado); end
        tick();
        checks++; if (listo !== 1'b0) begin errors++; $display("FAIL conv_listo_width got=%b exp=0", listo); end
        checks++; if (dig !== 16'h1234) begin errors++; $display("FAIL conv_hold got=%h exp=1234", dig); end
    endtask
    task automatic test_blanking;
        logic [13:0] vals [4] = '{14'd7, 14'd0, 14'd1005, 14'd1010};
        logic [15:0] eb   [4] = '{16'hFFF7, 16'hFFF0, 16'h1005, 16'h1010};
        logic [15:0] en   [4] = '{16'h0007, 16'h0000, 16'h1005, 16'h1010};
        int lat, n_oc;
        for (int i = 0; i < 4; i++) begin
            convertir(vals[i], lat, n_oc);
            checks++; if (dig !== eb[i]) begin errors++; $display("FAIL blank_%0d got=%h exp=%h", vals[i], dig, eb[i]); end
            checks++; if (dig_nb !== en[i]) begin errors++; $display("FAIL noblank_%0d got=%h exp=%h", vals[i], dig_nb, en[i]); end
        end
    endtask
    task automatic test_limites;
        logic [13:0] vals [4] = '{14'd9999, 14'd10000, 14'd16383, 14'd42};
        logic [15:0] eb   [4] = '{16'h9999, 16'hFFFF, 16'hFFFF, 16'hFF42};
        logic        ov   [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        int lat, n_oc;
        for (int i = 0; i < 4; i++) begin
            convertir(vals[i], lat, n_oc);
            checks++; if (dig !== eb[i]) begin errors++; $display("FAIL limit_%0d got=%h exp=%h", vals[i], dig, eb[i]); end
            checks++; if (desbordado !== ov[i]) begin errors++; $display("FAIL ovf_%0d got=%b exp=%b", vals[i], desbordado, ov[i]); end
        end
    endtask
    task automatic test_scan;
        logic [3:0] pat [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        int exp_sel;
        do_reset();
        dato_bin = 14'd8;
        for (int t = 1; t <= 24; t++) begin
            cargar = (t == 3);
            tick();
            exp_sel = (t / 4) % 4;
            checks++; if (seleccion !== 2'(exp_sel) || anodos !== pat[exp_sel])
                begin errors++; $display("FAIL scan_t%0d got=%0d/%b exp=%0d/%b", t, seleccion, anodos, exp_sel, pat[exp_sel]); end
        end
        cargar = 0;
        checks++; if (dig !== 16'hFFF8) begin errors++; $display("FAIL scan_conv got=%h exp=fff8", dig); end
    endtask
    task automatic test_back_to_back;
        int lat = 0, seen = 0, n_oc;
        dato_bin = 14'd321;
        cargar   = 1;
        tick();
        cargar = 0;
        repeat (5) begin tick(); lat++; end
        dato_bin = 14'd9876;
        cargar   = 1;
        tick();
        lat++;
        cargar   = 0;
        dato_bin = 14'd0;
        while (!listo && lat < 40) begin tick(); lat++; end
        checks++; if (lat !== 15) begin errors++; $display("FAIL ignore_latency got=%0d exp=15", lat); end
        checks++; if (dig !== 16'hF321) begin errors++; $display("FAIL ignore_dig got=%h exp=f321", dig); end
        repeat (20) begin tick(); if (listo) seen++; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL ignore_queued got=%0d exp=0", seen); end
        convertir(14'd55, lat, n_oc);
        checks++; if (lat !== 15 || dig !== 16'hFF55) begin errors++; $display("FAIL b2b_55 got=%0d/%h exp=15/ff55", lat, dig); end
        tick();
        convertir(14'd56, lat, n_oc);
        checks++; if (lat !== 15 || dig !== 16'hFF56) begin errors++; $display("FAIL b2b_56 got=%0d/%h exp=15/ff56", lat, dig); end
    endtask
    task automatic test_reset_mid;
        int seen = 0;
        dato_bin = 14'd4321;
        cargar   = 1;
        tick();
        cargar = 0;
        repeat (5) tick();
        #2 reset = 1;
        #1;
        checks++; if (dig !== 16'hFFF0) begin errors++; $display("FAIL midreset_dig got=%h exp=fff0", dig); end
        checks++; if ({ocupado, listo, desbordado} !== 3'b000) begin errors++; $display("FAIL midreset_flags got=%b exp=000", {ocupado, listo, desbordado}); end
        checks++; if (seleccion !== 2'd0 || anodos !== 4'b1110) begin errors++; $display("FAIL midreset_scan got=%0d/%b exp=0/1110", seleccion, anodos); end
        dato_bin = 14'd77;
        cargar   = 1;
        tick();
        cargar = 0;
        reset  = 0;
        repeat (25) begin tick(); if (listo) seen++; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL midreset_listo got=%0d exp=0", seen); end
        checks++; if (dig !== 16'hFFF0) begin errors++; $display("FAIL midreset_hold got=%h exp=fff0", dig); end
    endtask
    initial begin
        test_reset();
        test_conversion();
        test_blanking();
        test_limites();
        test_scan();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/controlador_barrido_bcd.md
Name: controlador_barrido_bcd

Overview:
Converts a binary value to four BCD digits with a sequential double-dabble converter. Time-multiplexes those digits onto a 4-digit common-anode 7-segment display. Drives the existing 7-segment decoder through its unidades/decenas/centenas/millares/seleccion inputs and drives the anode lines directly. Provides a load/busy/done handshake toward the upstream binary source.

Parameters:
ANCHO_BIN, 14, width of dato_bin; legal range 4..14.
DIV_REFRESCO, 50000, clock cycles each digit stays selected; minimum 2.
BLANK_CEROS, 1, 1 = blank leading zeros, 0 = show all digits.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
dato_bin  in  ANCHO_BIN  unsigned binary value to display.
cargar  in  1  conversion request; sampled only in REPOSO.
ocupado  out  1  high while a conversion is in progress.
listo  out  1  one-cycle pulse when new digits are latched.
desbordado  out  1  latched value exceeded 9999.
unidades, decenas, centenas, millares  out  4 each  BCD digits to the decoder; 4'hF = blank.
seleccion  out  2  digit select to the decoder.
anodos  out  4  active-low digit enables; bit i corresponds to seleccion==i.

Behaviour:
- Reset values (asynchronous, active-high, single clock clk):
  - FSM = REPOSO; ocupado=0; listo=0; desbordado=0; seleccion=00; anodos=4'b1110; refresh counter=0.
  - unidades=4'h0.
  - decenas/centenas/millares = 4'hF if BLANK_CEROS=1, else 4'h0.
- FSM states: REPOSO, CONVERTIR, ACTUALIZAR.
- REPOSO, cargar=1 at edge E0:
  - Capture dato_bin into the shift register; clear the 16-bit BCD accumulator and the iteration counter.
  - Compute ovf = (dato_bin > 9999).
  - Move to CONVERTIR; ocupado=1.
- CONVERTIR, one iteration per edge:
  - For each BCD nibble, add 3 if it is >=5.
  - Then shift {bcd, bin} left by one.
  - After ANCHO_BIN iterations, move to ACTUALIZAR.
- ACTUALIZAR edge (E0+ANCHO_BIN+1):
  - Register the digit outputs and desbordado=ovf.
  - Pulse listo=1 for exactly one cycle; ocupado=0; return to REPOSO.
- Latency: listo and the new digits appear after edge E0+ANCHO_BIN+1. ocupado is high for ANCHO_BIN+1 cycles.
- Digit outputs change only at the ACTUALIZAR edge and stay stable at all other times.
- Overflow (ovf=1): all four digits = 4'hF (display blank); desbordado=1. The next valid conversion clears desbordado.
- Blanking (BLANK_CEROS=1):
  - Scan from millares down to decenas; each leading zero digit becomes 4'hF until the first nonzero digit.
  - unidades is never blanked.
  - Interior zeros are kept.
- cargar while ocupado=1 is ignored; it is neither queued nor able to restart the conversion.
- A new cargar is accepted in the cycle after listo.
- Scan:
  - The refresh counter is free-running and counts 0..DIV_REFRESCO-1.
  - At terminal count: counter returns to 0, seleccion advances 00→01→10→11→00, and anodos is updated on the same edge.
  - anodos mapping: 00→1110, 01→1101, 10→1011, 11→0111.
  - Scanning is independent of conversion and never stalls.
  - Blanked digits keep their anode enabled; the decoder outputs all segments off for 4'hF.
- Reset asserted mid-conversion: abort immediately, outputs return to reset values, no listo pulse after release.
- cargar and reset together: reset wins.

Decomposition:
- Shared package contents:
  - FSM state encodings.
  - DIGITO_BLANCO=4'hF and MAX_BCD=9999.
  - The four active-low anode patterns.
- Sub-module conversor_binario_bcd:
  - Contains the double-dabble shift register, iteration counter, add-3 logic, and start/done handshake.
  - The top level holds the overflow compare, blanking, output registers, and scan counter.

Test Plan:
- Reset, then release with no cargar → digits 0,F,F,F (millares..unidades = F,F,F,0); seleccion=00; anodos=1110; ocupado=0; listo=0.
- dato_bin=1234, one-cycle cargar → ocupado high 15 cycles; listo pulse at E0+15; millares=1, centenas=2, decenas=3, unidades=4; desbordado=0.
- Blanking with BLANK_CEROS=1:
  - 7 → F,F,F,7.
  - 0 → F,F,F,0.
  - 1005 → 1,0,0,5.
  - With BLANK_CEROS=0, 7 → 0,0,0,7.
- Boundary values:
  - 9999 → 9,9,9,9 with desbordado=0.
  - 10000 → F,F,F,F with desbordado=1.
  - 16383 → desbordado=1.
  - Then 42 → F,F,4,2 with desbordado=0.
- DIV_REFRESCO=4 → seleccion advances every 4 cycles 00,01,10,11,00; anodos 1110,1101,1011,0111,1110; no disturbance during a conversion.
- cargar pulsed again while ocupado → result unchanged (first value only); reset pulsed mid-conversion → reset values, no listo.
